// File: rtl/cache_ram.sv
// cache_ram: DATA_LEN independent banks sharing one line index.
// Writes broadcast wdata to every enabled bank; reads pick the lowest-numbered
// enabled bank and return its entry through a single output register
// (read-first on a same-cycle write). Only the output register is reset.
module cache_ram #(
  parameter int DATA_LEN   = 4,
  parameter int DATA_PACK  = 2,
  parameter int DATA_WIDTH = 32,
  parameter int DATA_NUM   = 64,
  parameter int ADDR_WIDTH = 6,
  localparam int W         = DATA_PACK * DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  srst_n,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [W-1:0]          wdata,
  input  logic [DATA_LEN-1:0]   ren,
  input  logic [DATA_LEN-1:0]   wen,
  output logic [W-1:0]          rdata
);

  localparam int IDX_W = (DATA_NUM > 1) ? $clog2(DATA_NUM) : 1;
  localparam int SEL_W = (DATA_LEN > 1) ? $clog2(DATA_LEN) : 1;

  // Bank storage; deliberately has no reset so contents survive srst_n.
  logic [W-1:0] bank_mem [DATA_LEN][DATA_NUM];

  logic                addr_ok_s;
  logic [IDX_W-1:0]    idx_s;
  logic                rd_any_s;
  logic [SEL_W-1:0]    rd_sel_s;
  logic [DATA_LEN-1:0] wr_en_s;
  logic [W-1:0]        rdata_d;
  logic [W-1:0]        rdata_q;

  // Address decode, read-bank priority select, write gating and next read data.
  always_comb begin
    // Zero-extended compare keeps this meaningful when 2^ADDR_WIDTH > DATA_NUM.
    addr_ok_s = ({{(32-ADDR_WIDTH){1'b0}}, addr} < 32'(DATA_NUM));
    idx_s     = addr[IDX_W-1:0];
    rd_any_s  = |ren;
    // Scan from the top so the lowest set ren bit wins.
    rd_sel_s  = '0;
    for (int k = DATA_LEN - 1; k >= 0; k--) begin
      rd_sel_s = ren[k] ? SEL_W'(k) : rd_sel_s;
    end
    // Writes are dropped while in reset or when the index is out of range.
    wr_en_s   = (srst_n && addr_ok_s) ? wen : '0;
    rdata_d   = rdata_q;
    if (rd_any_s && addr_ok_s) begin
      rdata_d = bank_mem[rd_sel_s][idx_s];
    end else if (rd_any_s) begin
      rdata_d = '0;
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Bank write port: every enabled bank takes the same wdata at idx.
  always_ff @(posedge clk) begin
    for (int k = 0; k < DATA_LEN; k++) begin
      if (wr_en_s[k]) begin
        bank_mem[k][idx_s] <= wdata;
      end
    end
  end

  // Output register; reads the pre-write contents, cleared asynchronously.
  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: tb/tb_cache_ram.sv
// Directed self-checking bench for cache_ram with default parameters.
module tb_cache_ram;

  logic        clk;
  logic        srst_n;
  logic [5:0]  addr;
  logic [63:0] wdata;
  logic [3:0]  ren;
  logic [3:0]  wen;
  logic [63:0] rdata;

  int errors;
  int checks;

  cache_ram dut (
    .clk    (clk),
    .srst_n (srst_n),
    .addr   (addr),
    .wdata  (wdata),
    .ren    (ren),
    .wen    (wen),
    .rdata  (rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One cycle: drive on negedge, let the rising edge happen, sample 1 ns after it.
  task automatic step(input logic [3:0] r, input logic [3:0] w,
                      input logic [5:0] a, input logic [63:0] d);
    @(negedge clk);
    ren   = r;
    wen   = w;
    addr  = a;
    wdata = d;
    @(posedge clk);
    #1;
    ren   = 4'b0000;
    wen   = 4'b0000;
  endtask

  function automatic logic [63:0] pat(input int k, input int a);
    return {16'hC0DE, 8'(k), 8'(a), ~(32'(k * 64 + a) ^ 32'h1357_9BDF)};
  endfunction

  initial begin
    logic [63:0] hold_v;
    errors = 0;
    checks = 0;
    clk    = 1'b0;
    srst_n = 1'b1;
    addr   = 6'd0;
    wdata  = 64'd0;
    ren    = 4'b0000;
    wen    = 4'b0000;

    // Reset asserts before any clock edge: rdata must clear asynchronously.
    #1 srst_n = 1'b0;
    #1 chk("reset_async", rdata, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    srst_n = 1'b1;
    step(4'b0000, 4'b0000, 6'd0, 64'd0);
    chk("idle_after_reset_1", rdata, 64'd0);
    step(4'b0000, 4'b0000, 6'd0, 64'd0);
    chk("idle_after_reset_2", rdata, 64'd0);

    // Basic write then read, one-cycle latency.
    step(4'b0000, 4'b0001, 6'd5, 64'h1111_2222_3333_4444);
    chk("write_no_read", rdata, 64'd0);
    step(4'b0001, 4'b0000, 6'd5, 64'd0);
    chk("read_b0_a5", rdata, 64'h1111_2222_3333_4444);

    // Bank isolation at the same address.
    step(4'b0000, 4'b0100, 6'd3, 64'hAAAA_AAAA_AAAA_AAAA);
    step(4'b0000, 4'b1000, 6'd3, 64'h5555_5555_5555_5555);
    step(4'b0100, 4'b0000, 6'd3, 64'd0);
    chk("iso_b2_a3", rdata, 64'hAAAA_AAAA_AAAA_AAAA);
    step(4'b1000, 4'b0000, 6'd3, 64'd0);
    chk("iso_b3_a3", rdata, 64'h5555_5555_5555_5555);

    // Multi-bank broadcast write.
    step(4'b0000, 4'b0011, 6'd9, 64'h0123_4567_89AB_CDEF);
    step(4'b0001, 4'b0000, 6'd9, 64'd0);
    chk("bcast_b0_a9", rdata, 64'h0123_4567_89AB_CDEF);
    step(4'b0010, 4'b0000, 6'd9, 64'd0);
    chk("bcast_b1_a9", rdata, 64'h0123_4567_89AB_CDEF);
    step(4'b0100, 4'b0000, 6'd9, 64'd0);
    chk("bcast_b2_a9_untouched", rdata === 64'h0123_4567_89AB_CDEF ? 64'd1 : 64'd0, 64'd0);

    // Read-first on same bank/address.
    step(4'b0000, 4'b0010, 6'd7, 64'h0000_0000_0000_000A);
    step(4'b0010, 4'b0010, 6'd7, 64'h0000_0000_0000_000B);
    chk("read_first_old", rdata, 64'h0000_0000_0000_000A);
    step(4'b0010, 4'b0000, 6'd7, 64'd0);
    chk("read_first_new", rdata, 64'h0000_0000_0000_000B);

    // Priority: ren=0110 returns bank1; then hold for three idle cycles.
    step(4'b0000, 4'b0100, 6'd7, 64'hDDDD_0000_DDDD_0000);
    step(4'b0110, 4'b0000, 6'd7, 64'd0);
    chk("priority_b1", rdata, 64'h0000_0000_0000_000B);
    step(4'b0000, 4'b0000, 6'd3, 64'd0);
    chk("hold_1", rdata, 64'h0000_0000_0000_000B);
    step(4'b0000, 4'b0000, 6'd9, 64'd0);
    chk("hold_2", rdata, 64'h0000_0000_0000_000B);
    step(4'b0000, 4'b0000, 6'd5, 64'd0);
    chk("hold_3", rdata, 64'h0000_0000_0000_000B);

    // Read of another bank is unaffected by a concurrent write.
    step(4'b0100, 4'b0010, 6'd7, 64'hEEEE_EEEE_EEEE_EEEE);
    chk("cross_bank_read", rdata, 64'hDDDD_0000_DDDD_0000);
    step(4'b0010, 4'b0000, 6'd7, 64'd0);
    chk("cross_bank_written", rdata, 64'hEEEE_EEEE_EEEE_EEEE);

    // Fill every entry of every bank with a distinct pattern.
    for (int k = 0; k < 4; k++) begin
      for (int a = 0; a < 64; a++) begin
        step(4'b0000, 4'b0001 << k, 6'(a), pat(k, a));
      end
    end

    // Put a read in flight, then drop reset between edges.
    step(4'b1000, 4'b0000, 6'd42, 64'd0);
    chk("pre_reset_read", rdata, pat(3, 42));
    hold_v = rdata;
    #2 srst_n = 1'b0;
    #1 chk("mid_reset_async", rdata, 64'd0);
    // Writes and reads during reset must be ignored.
    step(4'b1111, 4'b1111, 6'd42, 64'hBAD0_BAD0_BAD0_BAD0);
    chk("reset_read_ignored", rdata, 64'd0);
    @(negedge clk);
    srst_n = 1'b1;
    step(4'b0000, 4'b0000, 6'd0, 64'd0);
    chk("post_reset_idle", rdata, 64'd0);
    step(4'b1000, 4'b0000, 6'd42, 64'd0);
    chk("post_reset_b3_a42", rdata, hold_v);

    // Every entry still holds its written value.
    for (int k = 0; k < 4; k++) begin
      for (int a = 0; a < 64; a++) begin
        step(4'b0001 << k, 4'b0000, 6'(a), 64'd0);
        chk($sformatf("readback_b%0d_a%0d", k, a), rdata, pat(k, a));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cache_ram.md
CACHE_RAM -- requirements
Module: cache_ram

Interface
REQ-001 Parameter DATA_LEN, default 4: number of independent banks per cache line.
REQ-002 Parameter DATA_PACK, default 2: words packed per bank entry.
REQ-003 Parameter DATA_WIDTH, default 32: bits per word.
REQ-004 Parameter DATA_NUM, default 64: entries (lines) per bank.
REQ-005 Parameter ADDR_WIDTH, default 6: index width.
REQ-006 Derived width W = DATA_PACK*DATA_WIDTH (64 by default), fixed at elaboration.
REQ-007 clk  input  1  single clock; all state changes on rising edge.
REQ-008 srst_n  input  1  reset, asynchronous, active-low.
REQ-009 addr  input  ADDR_WIDTH  line index shared by all banks.
REQ-010 wdata  input  W  write data for every enabled bank.
REQ-011 ren  input  DATA_LEN  per-bank read enables.
REQ-012 wen  input  DATA_LEN  per-bank write enables.
REQ-013 rdata  output  W  registered read data.

Function
REQ-014 Storage SHALL be DATA_LEN banks, each DATA_NUM entries of W bits.
REQ-015 Write: at a rising edge, for every k with wen[k]=1 and addr<DATA_NUM, bank[k][addr] SHALL take wdata; banks with wen[k]=0 unchanged.
REQ-016 Multiple wen bits set SHALL write the same wdata to all enabled banks in the same cycle.
REQ-017 Read: at a rising edge with any ren bit set, rdata SHALL take bank[j][addr], where j is the lowest-numbered set ren bit; latency exactly 1 cycle.
REQ-018 ren all zero SHALL hold rdata at its previous value.
REQ-019 Read and write to the same bank and addr in one cycle SHALL return the old (pre-write) contents (read-first); the new value is visible from the next read.
REQ-020 Read of a bank different from the one written in the same cycle SHALL be unaffected by the write.
REQ-021 addr >= DATA_NUM (only possible when 2^ADDR_WIDTH > DATA_NUM): writes ignored, read returns all zeros.
REQ-022 No handshake; ren/wen are single-cycle strobes and may be asserted every cycle back-to-back.
REQ-023 Bank k occupies no bit field of rdata other than the full W; there is no word/byte masking within a bank.

Reset
REQ-024 srst_n low SHALL clear rdata to 0 immediately, without waiting for clk.
REQ-025 Memory contents SHALL NOT be cleared by reset; locations never written read as unknown.
REQ-026 While srst_n is low, writes and reads SHALL be ignored; operation resumes on the first rising edge after deassertion.
REQ-027 Reset asserted mid-operation SHALL drop any read in flight (rdata=0) and SHALL NOT corrupt previously written entries.

Verification
REQ-028 Reset then idle: srst_n=0 -> rdata=0 asynchronously; after release with ren=0 rdata stays 0.
REQ-029 Write bank0 addr 5 = 64'h1111_2222_3333_4444 (wen=4'b0001), next cycle ren=4'b0001 addr 5 -> rdata=64'h1111_2222_3333_4444 one cycle later.
REQ-030 Bank isolation: wen=4'b0100 addr 3 = 64'hAAAA..., wen=4'b1000 addr 3 = 64'h5555...; ren=4'b0100 -> 64'hAAAA..., ren=4'b1000 -> 64'h5555...
REQ-031 Read-first: bank1 addr 7 holds 64'hA; same cycle wen=4'b0010 wdata=64'hB, ren=4'b0010 -> rdata=64'hA; next read -> 64'hB.
REQ-032 Priority and hold: ren=4'b0110 -> bank1 data; then ren=0 for 3 cycles -> rdata unchanged.
REQ-033 Reset mid-run: fill addr 0..63 of all banks, pulse srst_n low -> rdata=0; afterwards every entry reads back its written value.
